// File: rtl/prog_mod_counter_pkg.sv
// Shared constants for the programmable modulus counter.
package prog_mod_counter_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;
endpackage

// File: rtl/prog_mod_counter_mod_shadow_reg.sv
// Modulus shadow register: holds a pending modulus and applies it on a transfer strobe.
module mod_shadow_reg #(
  parameter int N         = 8,
  parameter int M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_m,
  input  logic [N-1:0] m_in,
  input  logic         xfer_en,
  output logic [N-1:0] m_active,
  output logic [N-1:0] m_next
);
  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] m_active_q, m_active_d;
  logic         pend_q, pend_d;
  logic         load_ok;

  always_comb begin
    load_ok    = load_m && (m_in != '0);
    shadow_d   = load_ok ? m_in : shadow_q;
    // the transfer consumes the old shadow; a same-cycle load re-arms pend
    pend_d     = (pend_q && !xfer_en) || load_ok;
    m_active_d = (pend_q && xfer_en) ? shadow_q : m_active_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      pend_q     <= 1'b0;
      m_active_q <= N'(M_DEFAULT);
    end else begin
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      m_active_q <= m_active_d;
    end
  end

  assign m_active = m_active_q;
  assign m_next   = pend_q ? shadow_q : m_active_q;
endmodule

// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulus counter with up/down, enable, one-shot and start/stop.
module prog_mod_counter
  import prog_mod_counter_pkg::*;
#(
  parameter int N         = 8,
  parameter int M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         dir_down,
  input  logic         load_m,
  input  logic [N-1:0] m_in,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         busy,
  output logic [N-1:0] m_active
);
  typedef enum logic {S_IDLE = ST_IDLE, S_RUN = ST_RUN} state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic         busy_q, busy_d;
  logic [N-1:0] m_next;
  logic [N-1:0] term;
  logic         xfer_en;

  mod_shadow_reg #(.N(N), .M_DEFAULT(M_DEFAULT)) u_shadow (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_m   (load_m),
    .m_in     (m_in),
    .xfer_en  (xfer_en),
    .m_active (m_active),
    .m_next   (m_next)
  );

  always_comb begin
    term     = dir_down ? '0 : (m_active - ONE);
    max_tick = (state_q == S_RUN) && en && (q_q == term);
    state_d  = state_q;
    q_d      = q_q;
    xfer_en  = (state_q == S_IDLE);
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
      xfer_en = 1'b1;
      q_d     = dir_down ? (m_next - ONE) : '0;
    end else if ((state_q == S_RUN) && en) begin
      if (q_q == term) begin
        // wrap edge: the shadow transfer lands here, so reload from m_next
        xfer_en = 1'b1;
        q_d     = dir_down ? (m_next - ONE) : '0;
        if (oneshot) state_d = S_IDLE;
      end else begin
        q_d = dir_down ? (q_q - ONE) : (q_q + ONE);
      end
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
endmodule
